ws2812_encoder: RTL
===================

WS2812_ENCODER -- requirements
Module: ws2812_encoder

Interface
REQ-001 Parameter T0H, default 14, high time of a 0-bit in clock cycles.
REQ-002 Parameter T1H, default 29, high time of a 1-bit in clock cycles.
REQ-003 Parameter TBIT, default 48, total bit period in clock cycles (TBIT > T1H > T0H >= 1).
REQ-004 Parameter TLATCH, default 1440, minimum low latch/reset period in clock cycles.
REQ-005 Port clock, input, 1, single system clock; all flops on its rising edge.
REQ-006 Port resetq, input, 1, reset; asynchronous, active-low.
REQ-007 Port grb, input, 24, pixel word, bit 23 transmitted first.
REQ-008 Port last, input, 1, marks the final pixel of a frame; qualified by valid.
REQ-009 Port valid, input, 1, pixel word present.
REQ-010 Port ready, output, 1, encoder accepts the word this cycle.
REQ-011 Port dout, output, 1, registered serial line data, fed to the dual-edge output flop.
REQ-012 Port busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 Transfer occurs on a rising clock edge where valid and ready are both high.
REQ-014 States: IDLE, HIGH, LOW, LATCH; one-hot or binary is free.
REQ-015 ready is high only in IDLE, or in LOW during the final cycle of bit 0 of a non-last word (zero-gap chaining).
REQ-016 On transfer: load grb into a 24-bit shift register, store last, set bit counter to 23, enter HIGH; dout goes 1 in the next cycle.
REQ-017 HIGH lasts T1H cycles if the current MSB is 1, else T0H cycles; then enter LOW with dout 0.
REQ-018 LOW lasts TBIT minus the HIGH time, so every bit spans exactly TBIT cycles.
REQ-019 At the end of LOW with bit counter > 0: shift left by one, decrement the counter, enter HIGH.
REQ-020 At the end of LOW with bit counter = 0 and stored last = 1: enter LATCH.
REQ-021 At the end of LOW with bit counter = 0, stored last = 0 and a transfer in that cycle: reload and enter HIGH with no gap.
REQ-022 At the end of LOW with bit counter = 0, stored last = 0 and no transfer: enter IDLE.
REQ-023 LATCH holds dout 0 for TLATCH cycles, then enters IDLE; ready stays low throughout.
REQ-024 IDLE holds dout 0.
REQ-025 A single down-counter times HIGH, LOW and LATCH; its width is clog2(max(TBIT, TLATCH)+1).
REQ-026 grb and last are ignored whenever valid is low or ready is low; valid may drop without penalty.

Reset
REQ-027 resetq low forces IDLE, dout 0, ready 1, busy 0, counters and shift register to 0.
REQ-028 Reset mid-bit or mid-latch aborts immediately; no partial bit completes; the next frame starts from IDLE.

Structure
REQ-029 State encoding and the default timing constants belong in the shared LED package for reuse by the frame buffer reader.
REQ-030 The module has no sub-modules; the dual-edge output flop is instantiated by the parent on dout, never inside.

Verification
REQ-031 Reset release, valid low for 100 cycles -> dout 0, ready 1, busy 0 throughout.
REQ-032 Single word grb=24'hA00000, last=1, defaults -> first bit high 29 cycles, low 19; second bit high 14, low 34; 24 bits in 1152 cycles, then dout 0 for 1440 cycles; busy then falls.
REQ-033 Two words 24'hFFFFFF (last=0), then 24'h000000 (last=1), valid held high -> second HIGH starts on the cycle after bit 0 of word one ends; 2304 data cycles, then latch.
REQ-034 Word with last=0 and no follow-up valid -> IDLE after 1152 cycles, no latch period, ready 1.
REQ-035 resetq pulled low at cycle 500 of a frame -> dout 0 and state IDLE at once; a new word after release is encoded with correct timing from bit 23.
REQ-036 valid toggled while ready is low, with grb changing every cycle -> transmitted bits match only the words captured on accepted transfers.

Source files
------------

// File: rtl/ws2812_encoder_pkg.sv
// Shared LED definitions: encoder state encoding and default WS2812 timing, also
// used by the frame buffer reader.
package ws2812_encoder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HIGH  = 2'd1;
    localparam logic [1:0] ST_LOW   = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam int WS_T0H    = 14;
    localparam int WS_T1H    = 29;
    localparam int WS_TBIT   = 48;
    localparam int WS_TLATCH = 1440;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_encoder.sv
// WS2812 serial encoder: turns 24-bit GRB words into NRZ high/low pulses, MSB first,
// with zero-gap chaining of words inside a frame and a latch period after the last one.
module ws2812_encoder
    import ws2812_encoder_pkg::*;
#(
    parameter int T0H    = WS_T0H,
    parameter int T1H    = WS_T1H,
    parameter int TBIT   = WS_TBIT,
    parameter int TLATCH = WS_TLATCH
) (
    input  logic        clock,
    input  logic        resetq,
    input  logic [23:0] grb,
    input  logic        last,
    input  logic        valid,
    output logic        ready,
    output logic        dout,
    output logic        busy
);

    localparam int CW = $clog2(max_int(TBIT, TLATCH) + 1);

    // Counter reload values are "duration - 1" because the phase ends when the counter hits 0.
    localparam logic [CW-1:0] HIGH0_LD = CW'(T0H - 1);
    localparam logic [CW-1:0] HIGH1_LD = CW'(T1H - 1);
    localparam logic [CW-1:0] LOW0_LD  = CW'(TBIT - T0H - 1);
    localparam logic [CW-1:0] LOW1_LD  = CW'(TBIT - T1H - 1);
    localparam logic [CW-1:0] LATCH_LD = CW'(TLATCH - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [4:0]    bit_q, bit_d;
    logic          last_q, last_d;
    logic          dout_q, dout_d;

    logic cnt_zero;
    logic xfer;

    assign cnt_zero = (cnt_q == '0);
    assign ready    = (state_q == ST_IDLE) ||
                      (state_q == ST_LOW && cnt_zero && bit_q == 5'd0 && !last_q);
    assign xfer     = valid && ready;
    assign busy     = (state_q != ST_IDLE);
    assign dout     = dout_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    shift_d = grb;
                    last_d  = last;
                    bit_d   = 5'd23;
                    cnt_d   = grb[23] ? HIGH1_LD : HIGH0_LD;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (cnt_zero) begin
                    cnt_d   = shift_q[23] ? LOW1_LD : LOW0_LD;
                    state_d = ST_LOW;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LOW: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (bit_q != 5'd0) begin
                    shift_d = {shift_q[22:0], 1'b0};
                    bit_d   = bit_q - 5'd1;
                    cnt_d   = shift_q[22] ? HIGH1_LD : HIGH0_LD;
                    state_d = ST_HIGH;
                end else if (last_q) begin
                    cnt_d   = LATCH_LD;
                    state_d = ST_LATCH;
                end else if (xfer) begin
                    // Next word of the frame starts right after this bit, no gap.
                    shift_d = grb;
                    last_d  = last;
                    bit_d   = 5'd23;
                    cnt_d   = grb[23] ? HIGH1_LD : HIGH0_LD;
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase

        dout_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            last_q  <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            dout_q  <= dout_d;
        end
    end

endmodule
